// File: rtl/scarv_ccx_trng_pkg.sv
// Shared types and defaults for the core-complex TRNG entropy source.
// Holds the Zkr OPST encoding, the FSM state set and the poll-word packer.
package scarv_ccx_trng_pkg;

    typedef enum logic [1:0] {
        OPST_BIST = 2'b00,
        OPST_WAIT = 2'b01,
        OPST_ES16 = 2'b10,
        OPST_DEAD = 2'b11
    } opst_e;

    typedef enum logic [1:0] {
        ST_BIST = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } trng_state_e;

    localparam int unsigned DEF_FIFO_DEPTH   = 4;
    localparam int unsigned DEF_RCT_CUTOFF   = 32;
    localparam int unsigned DEF_APT_WINDOW   = 512;
    localparam int unsigned DEF_APT_CUTOFF   = 400;
    localparam int unsigned DEF_BIST_SAMPLES = 1024;
    localparam int unsigned DEF_FAIL_LIMIT   = 4;
    localparam int unsigned SEED_W           = 16;

    function automatic logic [31:0] pack_poll(input opst_e opst, input logic [15:0] seed);
        return {opst, 14'b0, seed};
    endfunction

endpackage

// File: rtl/scarv_ccx_trng_health.sv
// Continuous health tests on the raw noise stream: repetition count and
// adaptive proportion. fail is combinational so the failing sample can be discarded.
module scarv_ccx_trng_health
    import scarv_ccx_trng_pkg::*;
#(
    parameter int unsigned RCT_CUTOFF = DEF_RCT_CUTOFF,
    parameter int unsigned APT_WINDOW = DEF_APT_WINDOW,
    parameter int unsigned APT_CUTOFF = DEF_APT_CUTOFF
) (
    input  logic f_clk,
    input  logic g_resetn,
    input  logic valid,
    input  logic sample_bit,
    input  logic clear,
    output logic fail
);

    localparam int unsigned RUN_W = $clog2(RCT_CUTOFF + 1);
    localparam int unsigned APT_W = $clog2(APT_WINDOW + 1);

    logic [RUN_W-1:0] run_r;
    logic [RUN_W-1:0] run_nxt_s;
    logic             last_r;
    logic [APT_W-1:0] win_r;
    logic [APT_W-1:0] ones_r;
    logic [APT_W-1:0] ones_nxt_s;
    logic             win_end_s;
    logic             rct_fail_s;
    logic             apt_fail_s;

    // Outcome of the current sample against both tests; run_r of zero means no sample yet.
    always_comb begin
        if ((run_r == '0) || (sample_bit != last_r)) begin
            run_nxt_s = RUN_W'(1);
        end else begin
            run_nxt_s = run_r + RUN_W'(1);
        end
        rct_fail_s = (run_nxt_s >= RUN_W'(RCT_CUTOFF));
        ones_nxt_s = ones_r + APT_W'(sample_bit);
        win_end_s  = (win_r == APT_W'(APT_WINDOW - 1));
        apt_fail_s = win_end_s && ((ones_nxt_s >= APT_W'(APT_CUTOFF)) ||
                                   (ones_nxt_s <= APT_W'(APT_WINDOW - APT_CUTOFF)));
        fail       = valid && (rct_fail_s || apt_fail_s);
    end

    // Test counters; any failure restarts both tests from scratch.
    always_ff @(posedge f_clk) begin
        if (!g_resetn || clear || fail) begin
            run_r  <= '0;
            last_r <= 1'b0;
            win_r  <= '0;
            ones_r <= '0;
        end else if (valid) begin
            run_r  <= run_nxt_s;
            last_r <= sample_bit;
            if (win_end_s) begin
                win_r  <= '0;
                ones_r <= '0;
            end else begin
                win_r  <= win_r + APT_W'(1);
                ones_r <= ones_nxt_s;
            end
        end
    end

endmodule

// File: rtl/scarv_ccx_trng.sv
// TRNG entropy source: health-tested noise packed into 16-bit seeds, buffered
// in a small FIFO and presented as the Zkr pollentropy word to the MMIO block.
module scarv_ccx_trng
    import scarv_ccx_trng_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int unsigned RCT_CUTOFF   = DEF_RCT_CUTOFF,
    parameter int unsigned APT_WINDOW   = DEF_APT_WINDOW,
    parameter int unsigned APT_CUTOFF   = DEF_APT_CUTOFF,
    parameter int unsigned BIST_SAMPLES = DEF_BIST_SAMPLES,
    parameter int unsigned FAIL_LIMIT   = DEF_FAIL_LIMIT
) (
    input  logic        f_clk,
    input  logic        g_resetn,
    input  logic        raw_valid,
    input  logic        raw_bit,
    input  logic        trng_read,
    output logic [31:0] trng_pollentropy,
    output logic        trng_dead
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned FCNT_W = $clog2(FAIL_LIMIT + 1);
    localparam int unsigned BCNT_W = $clog2(BIST_SAMPLES + 1);

    trng_state_e       state_r, state_nxt_s;
    logic [FCNT_W-1:0] fail_cnt_r, fail_cnt_inc_s, fail_cnt_nxt_s;
    logic [BCNT_W-1:0] bist_cnt_r, bist_cnt_nxt_s;
    logic [14:0]       shift_r, shift_nxt_s;
    logic [3:0]        bit_cnt_r, bit_cnt_nxt_s;
    logic [15:0]       fifo_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, wr_ptr_nxt_s, rd_ptr_r, rd_ptr_nxt_s;
    logic [CNT_W-1:0]  count_r, count_nxt_s;
    logic [15:0]       seed_s, head_nxt_s;
    logic [31:0]       poll_nxt_s;
    logic sample_s, clear_s, fail_s, good_s, in_run_s, run_smp_s;
    logic pop_s, push_s, seed_done_s, bist_done_s;

    scarv_ccx_trng_health #(
        .RCT_CUTOFF (RCT_CUTOFF),
        .APT_WINDOW (APT_WINDOW),
        .APT_CUTOFF (APT_CUTOFF)
    ) u_health (
        .f_clk      (f_clk),
        .g_resetn   (g_resetn),
        .valid      (sample_s),
        .sample_bit (raw_bit),
        .clear      (clear_s),
        .fail       (fail_s)
    );

    // Per-cycle events: sample acceptance, seed completion, push/pop and BIST exit.
    always_comb begin
        sample_s       = raw_valid && (state_r != ST_DEAD);
        clear_s        = (state_r == ST_DEAD);
        good_s         = sample_s && !fail_s;
        in_run_s       = (state_r == ST_RUN);
        run_smp_s      = good_s && in_run_s;
        pop_s          = trng_read && in_run_s && (count_r != '0);
        seed_s         = {shift_r, raw_bit};
        seed_done_s    = run_smp_s && (bit_cnt_r == 4'd15);
        push_s         = seed_done_s && ((count_r != CNT_W'(FIFO_DEPTH)) || pop_s);
        bist_done_s    = good_s && (state_r == ST_BIST) &&
                         (bist_cnt_r == BCNT_W'(BIST_SAMPLES - 1));
        fail_cnt_inc_s = fail_cnt_r + FCNT_W'(1);
    end

    // Next-state values; a health failure flushes every datapath structure.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_BIST, ST_RUN: begin
                if (fail_s) begin
                    state_nxt_s = (fail_cnt_inc_s >= FCNT_W'(FAIL_LIMIT)) ? ST_DEAD : ST_BIST;
                end else if (bist_done_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_DEAD: state_nxt_s = ST_DEAD;
            default: state_nxt_s = ST_DEAD;
        endcase

        if (fail_s) begin
            fail_cnt_nxt_s = fail_cnt_inc_s;
            bist_cnt_nxt_s = '0;
            shift_nxt_s    = '0;
            bit_cnt_nxt_s  = 4'd0;
            wr_ptr_nxt_s   = '0;
            rd_ptr_nxt_s   = '0;
            count_nxt_s    = '0;
        end else begin
            fail_cnt_nxt_s = bist_done_s ? '0 : fail_cnt_r;
            if (good_s && (state_r == ST_BIST)) begin
                bist_cnt_nxt_s = bist_done_s ? '0 : (bist_cnt_r + BCNT_W'(1));
            end else begin
                bist_cnt_nxt_s = bist_cnt_r;
            end
            if (run_smp_s) begin
                shift_nxt_s   = {shift_r[13:0], raw_bit};
                bit_cnt_nxt_s = seed_done_s ? 4'd0 : (bit_cnt_r + 4'd1);
            end else begin
                shift_nxt_s   = shift_r;
                bit_cnt_nxt_s = bit_cnt_r;
            end
            wr_ptr_nxt_s = wr_ptr_r + PTR_W'(push_s);
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(pop_s);
            count_nxt_s  = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

    // Poll word for the next cycle; the new head may be the seed being written now.
    always_comb begin
        if (push_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = seed_s;
        end else begin
            head_nxt_s = fifo_r[rd_ptr_nxt_s];
        end
        poll_nxt_s = pack_poll(OPST_DEAD, 16'h0000);
        case (state_nxt_s)
            ST_BIST: poll_nxt_s = pack_poll(OPST_BIST, 16'h0000);
            ST_RUN: begin
                if (count_nxt_s != '0) begin
                    poll_nxt_s = pack_poll(OPST_ES16, head_nxt_s);
                end else begin
                    poll_nxt_s = pack_poll(OPST_WAIT, 16'h0000);
                end
            end
            ST_DEAD: poll_nxt_s = pack_poll(OPST_DEAD, 16'h0000);
            default: poll_nxt_s = pack_poll(OPST_DEAD, 16'h0000);
        endcase
    end

    // State, FIFO storage and registered outputs.
    always_ff @(posedge f_clk) begin
        if (!g_resetn) begin
            state_r          <= ST_BIST;
            fail_cnt_r       <= '0;
            bist_cnt_r       <= '0;
            shift_r          <= '0;
            bit_cnt_r        <= 4'd0;
            wr_ptr_r         <= '0;
            rd_ptr_r         <= '0;
            count_r          <= '0;
            trng_pollentropy <= 32'h0000_0000;
            trng_dead        <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_r[i] <= 16'h0000;
            end
        end else begin
            state_r          <= state_nxt_s;
            fail_cnt_r       <= fail_cnt_nxt_s;
            bist_cnt_r       <= bist_cnt_nxt_s;
            shift_r          <= shift_nxt_s;
            bit_cnt_r        <= bit_cnt_nxt_s;
            wr_ptr_r         <= wr_ptr_nxt_s;
            rd_ptr_r         <= rd_ptr_nxt_s;
            count_r          <= count_nxt_s;
            trng_pollentropy <= poll_nxt_s;
            trng_dead        <= (state_nxt_s == ST_DEAD);
            if (push_s) begin
                fifo_r[wr_ptr_r] <= seed_s;
            end
        end
    end

endmodule

// File: tb/tb_scarv_ccx_trng.sv
// Self-checking bench for scarv_ccx_trng: a table of scenario rows with
// expected poll words, plus a randomized phase against a queue-based model.
module tb_scarv_ccx_trng;

    localparam int DEPTH = 4;
    localparam int RCT   = 32;
    localparam int WIN   = 512;
    localparam int CUT   = 400;
    localparam int BISTN = 1024;
    localparam int FLIM  = 4;

    localparam int K_ALT = 0, K_READ = 1, K_SEED = 2, K_PPSEED = 3;
    localparam int K_ONES = 4, K_APT = 5, K_JUNK = 6, K_RESET = 7;

    logic        f_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        raw_valid = 1'b0;
    logic        raw_bit = 1'b0;
    logic        trng_read = 1'b0;
    logic [31:0] trng_pollentropy;
    logic        trng_dead;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 0=BIST, 1=RUN, 2=DEAD
    int          m_state, m_fail, m_bist, m_rct_len;
    bit          m_rct_last;
    bit          m_apt[$];
    bit          m_bits[$];
    logic [15:0] m_fifo[$];

    typedef struct {
        int          kind;
        int          n;
        logic [15:0] arg;
        logic [31:0] exp;
        logic [31:0] mask;
        logic        exp_dead;
    } vec_t;
    vec_t tbl[$];

    scarv_ccx_trng #(
        .FIFO_DEPTH(DEPTH), .RCT_CUTOFF(RCT), .APT_WINDOW(WIN),
        .APT_CUTOFF(CUT), .BIST_SAMPLES(BISTN), .FAIL_LIMIT(FLIM)
    ) dut (
        .f_clk(f_clk), .g_resetn(g_resetn), .raw_valid(raw_valid), .raw_bit(raw_bit),
        .trng_read(trng_read), .trng_pollentropy(trng_pollentropy), .trng_dead(trng_dead)
    );

    always #5 f_clk = ~f_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_word();
        case (m_state)
            1:       return (m_fifo.size() > 0) ? {2'b10, 14'b0, m_fifo[0]} : 32'h4000_0000;
            2:       return 32'hC000_0000;
            default: return 32'h0000_0000;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_fail = 0; m_bist = 0; m_rct_len = 0; m_rct_last = 1'b0;
        m_apt.delete(); m_bits.delete(); m_fifo.delete();
    endtask

    task automatic model_update(input bit v, input bit b, input bit rd);
        bit pop, fail;
        int ones;
        logic [15:0] s;
        pop  = rd && (m_state == 1) && (m_fifo.size() > 0);
        fail = 1'b0;
        if (v && m_state != 2) begin
            m_rct_len  = (m_rct_len == 0 || b != m_rct_last) ? 1 : m_rct_len + 1;
            m_rct_last = b;
            if (m_rct_len >= RCT) fail = 1'b1;
            m_apt.push_back(b);
            if (m_apt.size() == WIN) begin
                ones = 0;
                foreach (m_apt[k]) ones += int'(m_apt[k]);
                if (ones >= CUT || ones <= WIN - CUT) fail = 1'b1;
                m_apt.delete();
            end
        end
        if (fail) begin
            m_fail++;
            m_fifo.delete(); m_bits.delete(); m_apt.delete();
            m_rct_len = 0; m_bist = 0;
            m_state = (m_fail >= FLIM) ? 2 : 0;
        end else begin
            if (pop) void'(m_fifo.pop_front());
            if (v && m_state == 0) begin
                m_bist++;
                if (m_bist == BISTN) begin
                    m_state = 1; m_bist = 0; m_fail = 0;
                end
            end else if (v && m_state == 1) begin
                m_bits.push_back(b);
                if (m_bits.size() == 16) begin
                    for (int k = 0; k < 16; k++) s[15-k] = m_bits[k];
                    if (m_fifo.size() < DEPTH) m_fifo.push_back(s);
                    m_bits.delete();
                end
            end
        end
    endtask

    // One clock with the given inputs, then compare the DUT against the model.
    task automatic step(input bit v, input bit b, input bit rd);
        raw_valid = v; raw_bit = b; trng_read = rd;
        @(posedge f_clk);
        model_update(v, b, rd);
        #1;
        chk("cycle_word", trng_pollentropy, model_word());
        chk("cycle_dead", {31'b0, trng_dead}, {31'b0, (m_state == 2)});
    endtask

    task automatic do_reset();
        g_resetn = 1'b0; raw_valid = 1'b1; raw_bit = 1'b1; trng_read = 1'b1;
        @(posedge f_clk);
        model_reset();
        #1;
        chk("reset_word", trng_pollentropy, 32'h0000_0000);
        chk("reset_dead", {31'b0, trng_dead}, 32'h0000_0000);
        g_resetn = 1'b1; raw_valid = 1'b0; trng_read = 1'b0;
    endtask

    task automatic apt_window(input int ones);
        int o;
        for (int blk = 0; blk < 16; blk++) begin
            o = ones / 16 + ((blk < ones % 16) ? 1 : 0);
            for (int k = 0; k < 32; k++) step(1'b1, (k < o), 1'b0);
        end
    endtask

    task automatic add(input int k, input int n, input logic [15:0] a,
                       input logic [31:0] e, input logic [31:0] m, input logic d);
        vec_t r;
        r.kind = k; r.n = n; r.arg = a; r.exp = e; r.mask = m; r.exp_dead = d;
        tbl.push_back(r);
    endtask

    initial begin
        logic [15:0] w;
        add(K_ALT,    1024, 16'h0000, 32'h4000_0000, 32'hFFFF_FFFF, 1'b0);
        add(K_ALT,      16, 16'h0000, 32'h8000_5555, 32'hFFFF_FFFF, 1'b0);
        add(K_READ,      1, 16'h0000, 32'h4000_0000, 32'hFFFF_FFFF, 1'b0);
        add(K_READ,      1, 16'h0000, 32'h4000_0000, 32'hFFFF_FFFF, 1'b0);
        add(K_SEED,      1, 16'h1234, 32'h8000_1234, 32'hFFFF_FFFF, 1'b0);
        add(K_SEED,      1, 16'h5A5A, 32'h8000_1234, 32'hFFFF_FFFF, 1'b0);
        add(K_SEED,      1, 16'h0F0F, 32'h8000_1234, 32'hFFFF_FFFF, 1'b0);
        add(K_SEED,      1, 16'hC3C3, 32'h8000_1234, 32'hFFFF_FFFF, 1'b0);
        add(K_SEED,      1, 16'hBEEF, 32'h8000_1234, 32'hFFFF_FFFF, 1'b0);
        add(K_READ,      1, 16'h0000, 32'h8000_5A5A, 32'hFFFF_FFFF, 1'b0);
        add(K_READ,      1, 16'h0000, 32'h8000_0F0F, 32'hFFFF_FFFF, 1'b0);
        add(K_READ,      1, 16'h0000, 32'h8000_C3C3, 32'hFFFF_FFFF, 1'b0);
        add(K_READ,      1, 16'h0000, 32'h4000_0000, 32'hFFFF_FFFF, 1'b0);
        add(K_SEED,      1, 16'h1111, 32'h8000_1111, 32'hFFFF_FFFF, 1'b0);
        add(K_SEED,      1, 16'h2222, 32'h8000_1111, 32'hFFFF_FFFF, 1'b0);
        add(K_SEED,      1, 16'h3333, 32'h8000_1111, 32'hFFFF_FFFF, 1'b0);
        add(K_SEED,      1, 16'h4444, 32'h8000_1111, 32'hFFFF_FFFF, 1'b0);
        add(K_PPSEED,    1, 16'h5550, 32'h8000_2222, 32'hFFFF_FFFF, 1'b0);
        add(K_READ,      1, 16'h0000, 32'h8000_3333, 32'hFFFF_FFFF, 1'b0);
        add(K_READ,      1, 16'h0000, 32'h8000_4444, 32'hFFFF_FFFF, 1'b0);
        add(K_READ,      1, 16'h0000, 32'h8000_5550, 32'hFFFF_FFFF, 1'b0);
        add(K_READ,      1, 16'h0000, 32'h4000_0000, 32'hFFFF_FFFF, 1'b0);
        add(K_SEED,      1, 16'h7770, 32'h8000_7770, 32'hFFFF_FFFF, 1'b0);
        add(K_SEED,      1, 16'h6660, 32'h8000_7770, 32'hFFFF_FFFF, 1'b0);
        add(K_ONES,     32, 16'h0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
        add(K_ALT,    1024, 16'h0000, 32'h4000_0000, 32'hFFFF_FFFF, 1'b0);
        add(K_ONES,     32, 16'h0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
        add(K_ONES,     32, 16'h0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
        add(K_ONES,     32, 16'h0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
        add(K_ONES,     32, 16'h0000, 32'hC000_0000, 32'hFFFF_FFFF, 1'b1);
        add(K_JUNK,     40, 16'h0000, 32'hC000_0000, 32'hFFFF_FFFF, 1'b1);
        add(K_RESET,     1, 16'h0000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
        add(K_ALT,    1024, 16'h0000, 32'h4000_0000, 32'hFFFF_FFFF, 1'b0);
        add(K_APT,       1, 16'd400,  32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
        add(K_ALT,    1024, 16'h0000, 32'h4000_0000, 32'hFFFF_FFFF, 1'b0);
        add(K_APT,       1, 16'd399,  32'h8000_0000, 32'hC000_0000, 1'b0);
        add(K_APT,       1, 16'd112,  32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
        add(K_ALT,    1024, 16'h0000, 32'h4000_0000, 32'hFFFF_FFFF, 1'b0);
        add(K_APT,       1, 16'd113,  32'h8000_0000, 32'hC000_0000, 1'b0);

        model_reset();
        do_reset();

        foreach (tbl[r]) begin
            case (tbl[r].kind)
                K_ALT:   for (int i = 0; i < tbl[r].n; i++) step(1'b1, i[0], 1'b0);
                K_READ:  for (int i = 0; i < tbl[r].n; i++) step(1'b0, 1'b0, 1'b1);
                K_ONES:  for (int i = 0; i < tbl[r].n; i++) step(1'b1, 1'b1, 1'b0);
                K_SEED, K_PPSEED: begin
                    w = tbl[r].arg;
                    for (int i = 0; i < 16; i++)
                        step(1'b1, w[15-i], (tbl[r].kind == K_PPSEED) && (i == 15));
                end
                K_APT:   apt_window(int'(tbl[r].arg));
                K_JUNK:  for (int i = 0; i < tbl[r].n; i++)
                             step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                  1'($urandom_range(0, 1)));
                K_RESET: do_reset();
                default: ;
            endcase
            n_checks++;
            if (((trng_pollentropy ^ tbl[r].exp) & tbl[r].mask) != 32'h0 ||
                trng_dead !== tbl[r].exp_dead) begin
                n_errors++;
                $display("FAIL row%0d: got word %h dead %b expected %h (mask %h) dead %b",
                         r, trng_pollentropy, trng_dead, tbl[r].exp, tbl[r].mask, tbl[r].exp_dead);
            end
        end

        // Randomized traffic with fair and biased noise, checked every cycle.
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            bit b;
            case ((c / 400) % 3)
                0:       b = 1'($urandom_range(0, 1));
                1:       b = ($urandom_range(0, 7) != 0);
                default: b = ($urandom_range(0, 7) == 0);
            endcase
            if (c == 2000) do_reset();
            step(($urandom_range(0, 3) != 0), b, ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
